chacha_aead_sequencer: RTL and testbench
========================================

Name: chacha_aead_sequencer

Overview:
Control sequencer for the ChaCha20-Poly1305 core. On a start pulse it configures the core, streams AAD into the core, and requests 512-bit keystream blocks. It XORs 128-bit payload beats against successive keystream slices, feeds the resulting ciphertext to the Poly1305 path, issues the lengths block, and combines the tag halves into the final tag. It sits between the top-level stream interfaces and chacha20_poly1305_core.

Parameters:
CNT_W, 36, width of the AAD and payload byte counters; zero-extended to 64 bits in len_block.

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous active-high reset
start  in  1  one-cycle pulse; begins an operation, ignored unless busy=0
dir  in  1  sampled at start: 0=encrypt (output is ciphertext), 1=decrypt (input is ciphertext)
aad_none  in  1  sampled at start: 1=no AAD phase
pld_none  in  1  sampled at start: 1=no payload phase
aad_in_valid/aad_in_ready  in/out  1/1  AAD input handshake
aad_in_data  in  128  AAD beat
aad_in_keep  in  16  byte enables, contiguous from bit 0
aad_in_last  in  1  final AAD beat
in_valid/in_ready  in/out  1/1  payload input handshake
in_data  in  128  payload beat
in_keep  in  16  byte enables, contiguous from bit 0
in_last  in  1  final payload beat
out_valid/out_ready  out/in  1/1  payload output handshake
out_data  out  128  XOR result; disabled bytes are 0
out_keep  out  16  copy of in_keep
out_last  out  1  copy of in_last
cfg_we  out  1  core configuration strobe
ks_req  out  1  keystream request pulse
ks_valid  in  1  keystream block valid
ks_data  in  512  keystream block
core_aad_valid/data/keep  out  1/128/16  AAD stream to the core
core_aad_ready  in  1  core accepts AAD
core_pld_valid/data/keep  out  1/128/16  ciphertext stream to the core
core_pld_ready  in  1  core accepts ciphertext
core_len_valid/core_len_block  out  1/128  lengths block to the core
core_len_ready  in  1  core accepts lengths block
tag_pre_xor, tagmask  in  128/128  tag halves from the core
tag_pre_xor_valid, tagmask_valid  in  1/1  tag-half valid flags
tag  out  128  tag_pre_xor XOR tagmask
tag_valid/tag_ready  out/in  1/1  tag output handshake
busy  out  1  1 whenever state is not IDLE

Behaviour:
- States: IDLE, CFG, AAD, KSREQ, KSWAIT, PLD, LEN, TAG, DONE.
- Reset (rst=1 at a clock edge, including mid-operation):
  - State goes to IDLE.
  - All outputs go to 0, all counters and flags clear, ks_buf clears.
  - Any in-flight beat is dropped.
- IDLE:
  - start=1 latches dir, aad_none and pld_none, clears counters, then goes to CFG.
- CFG:
  - Lasts exactly one cycle with cfg_we=1.
  - Next state is AAD if aad_none=0, else KSREQ if pld_none=0, else LEN.
- AAD (combinational pass-through):
  - core_aad_valid = aad_in_valid; aad_in_ready = core_aad_ready; data and keep pass through.
  - On each accepted beat, aad_cnt += popcount(keep).
  - On an accepted last beat: go to KSREQ if pld_none=0, else LEN.
- KSREQ:
  - Lasts one cycle with ks_req=1, then goes to KSWAIT.
- KSWAIT:
  - On ks_valid: ks_buf <= ks_data, slice idx <= 0, go to PLD.
- PLD:
  - xor = in_data ^ ks_buf[128*idx +: 128], with bytes masked by in_keep.
  - core_pld_data = xor when dir=0, in_data when dir=1; core_pld_keep = in_keep.
  - out_data = xor.
  - Handshake:
    - out_valid = in_valid & core_pld_ready
    - core_pld_valid = in_valid & out_ready
    - in_ready = out_ready & core_pld_ready
  - A beat transfers only when in_valid, out_ready and core_pld_ready are all 1 in the same cycle.
  - On a transfer: pld_cnt += popcount(in_keep).
    - in_last=1: go to LEN.
    - Else if idx=3: go to KSREQ (next block).
    - Else idx += 1.
  - Slice order: idx 0 uses ks_data[127:0], idx 3 uses [511:384].
  - A partial keep on a non-last beat is an illegal input; behaviour is unspecified.
- LEN:
  - core_len_block = {zext64(aad_cnt), zext64(pld_cnt)}.
  - core_len_valid stays 1 until core_len_ready, then go to TAG.
- TAG:
  - Latch each tag half when its valid is seen; the two may arrive in different cycles or the same cycle.
  - When both are held: tag <= pre ^ mask, go to DONE.
- DONE:
  - tag_valid=1 and tag is stable until tag_ready=1; then return to IDLE with tag_valid=0.
- start is ignored whenever busy=1.
- Counters wrap at 2^CNT_W with no flag.

Test Plan:
1. Encrypt with aad_none=0, pld_none=0: AAD of 1 beat keep=0x0FFF, payload of 5 full beats with the last beat keep=0x00FF -> cfg_we pulses once, exactly 2 ks_req pulses, out_data = in ^ matching slice with bytes 8-15 of the last beat = 0, core_len_block = {64'd12, 64'd72}.
2. Decrypt (dir=1), 1 beat, in_data=all 0xFF: core_pld_data = in_data; out_data = ~ks slice0; lengths {0,16} with aad_none=1.
3. Backpressure: toggle out_ready and core_pld_ready independently over 8 beats -> no beat is duplicated or lost, and idx advances only on a 3-way transfer.
4. aad_none=1, pld_none=1 -> CFG then LEN with block=0, no ks_req; tagmask_valid 3 cycles before tag_pre_xor_valid -> tag = XOR of the two, tag_valid held for 4 cycles while tag_ready=0.
5. Assert rst in PLD mid-block -> next cycle busy=0 and all outputs 0; a new start then runs normally from CFG.
6. start pulsed while busy -> ignored; cfg_we does not pulse again.

Source files
------------

// File: rtl/chacha_aead_sequencer.sv
// Control sequencer for the ChaCha20-Poly1305 core: configures the core,
// forwards AAD, fetches keystream blocks, XORs payload beats, issues the
// lengths block and assembles the final tag.
module chacha_aead_sequencer #(
  parameter int CNT_W = 36
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         dir,
  input  logic         aad_none,
  input  logic         pld_none,
  input  logic         aad_in_valid,
  output logic         aad_in_ready,
  input  logic [127:0] aad_in_data,
  input  logic [15:0]  aad_in_keep,
  input  logic         aad_in_last,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  input  logic [15:0]  in_keep,
  input  logic         in_last,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic [15:0]  out_keep,
  output logic         out_last,
  output logic         cfg_we,
  output logic         ks_req,
  input  logic         ks_valid,
  input  logic [511:0] ks_data,
  output logic         core_aad_valid,
  output logic [127:0] core_aad_data,
  output logic [15:0]  core_aad_keep,
  input  logic         core_aad_ready,
  output logic         core_pld_valid,
  output logic [127:0] core_pld_data,
  output logic [15:0]  core_pld_keep,
  input  logic         core_pld_ready,
  output logic         core_len_valid,
  output logic [127:0] core_len_block,
  input  logic         core_len_ready,
  input  logic [127:0] tag_pre_xor,
  input  logic [127:0] tagmask,
  input  logic         tag_pre_xor_valid,
  input  logic         tagmask_valid,
  output logic [127:0] tag,
  output logic         tag_valid,
  input  logic         tag_ready,
  output logic         busy
);

  localparam logic [3:0] S_IDLE   = 4'd0;
  localparam logic [3:0] S_CFG    = 4'd1;
  localparam logic [3:0] S_AAD    = 4'd2;
  localparam logic [3:0] S_KSREQ  = 4'd3;
  localparam logic [3:0] S_KSWAIT = 4'd4;
  localparam logic [3:0] S_PLD    = 4'd5;
  localparam logic [3:0] S_LEN    = 4'd6;
  localparam logic [3:0] S_TAG    = 4'd7;
  localparam logic [3:0] S_DONE   = 4'd8;

  logic [3:0]       state;
  logic             dir_r, aad_none_r, pld_none_r;
  logic [CNT_W-1:0] aad_cnt, pld_cnt;
  logic [511:0]     ks_buf;
  logic [1:0]       idx;
  logic [127:0]     pre_r, mask_r, tag_r;
  logic             pre_ok, mask_ok;

  logic [127:0] ks_slice, xor_data, pre_cur, mask_cur;
  logic         aad_xfer, pld_xfer, pre_have, mask_have;

  function automatic logic [4:0] popcount16(input logic [15:0] k);
    logic [4:0] n;
    n = '0;
    for (int b = 0; b < 16; b++) n = n + 5'(k[b]);
    return n;
  endfunction

  function automatic logic [127:0] keep_mask(input logic [15:0] k);
    logic [127:0] m;
    for (int b = 0; b < 16; b++) m[8*b +: 8] = {8{k[b]}};
    return m;
  endfunction

  // Datapath helpers: current keystream slice, masked XOR, handshake events, tag halves.
  always_comb begin
    ks_slice  = ks_buf[{idx, 7'd0} +: 128];
    xor_data  = (in_data ^ ks_slice) & keep_mask(in_keep);
    aad_xfer  = (state == S_AAD) && aad_in_valid && core_aad_ready;
    pld_xfer  = (state == S_PLD) && in_valid && out_ready && core_pld_ready;
    pre_have  = pre_ok  || tag_pre_xor_valid;
    mask_have = mask_ok || tagmask_valid;
    pre_cur   = pre_ok  ? pre_r  : tag_pre_xor;
    mask_cur  = mask_ok ? mask_r : tagmask;
  end

  // Output decode: every output is idle-zero unless the current state drives it.
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    aad_in_ready   = 1'b0;
    in_ready       = 1'b0;
    out_valid      = 1'b0;
    out_data       = '0;
    out_keep       = '0;
    out_last       = 1'b0;
    cfg_we         = 1'b0;
    ks_req         = 1'b0;
    core_aad_valid = 1'b0;
    core_aad_data  = '0;
    core_aad_keep  = '0;
    core_pld_valid = 1'b0;
    core_pld_data  = '0;
    core_pld_keep  = '0;
    core_len_valid = 1'b0;
    core_len_block = '0;
    tag_valid      = 1'b0;
    case (state)
      S_CFG:   cfg_we = 1'b1;
      S_AAD: begin
        core_aad_valid = aad_in_valid;
        aad_in_ready   = core_aad_ready;
        core_aad_data  = aad_in_data;
        core_aad_keep  = aad_in_keep;
      end
      S_KSREQ: ks_req = 1'b1;
      S_PLD: begin
        // Each side sees valid only when the other sink can also take the beat,
        // so a beat is never delivered to one sink and not the other.
        out_valid      = in_valid & core_pld_ready;
        core_pld_valid = in_valid & out_ready;
        in_ready       = out_ready & core_pld_ready;
        out_data       = xor_data;
        out_keep       = in_keep;
        out_last       = in_last;
        core_pld_data  = dir_r ? in_data : xor_data;
        core_pld_keep  = in_keep;
      end
      S_LEN: begin
        core_len_valid = 1'b1;
        core_len_block = {64'(aad_cnt), 64'(pld_cnt)};
      end
      S_DONE:  tag_valid = 1'b1;
      default: ;
    endcase
  end

  assign tag  = tag_r;
  assign busy = (state != S_IDLE);

  // Sequencer state, counters, keystream buffer and tag assembly.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: ks_buf is a plain register, not a memory, so clearing it on reset is cheap and keeps stale keystream off the outputs.
      state      <= S_IDLE;
      dir_r      <= 1'b0;
      aad_none_r <= 1'b0;
      pld_none_r <= 1'b0;
      aad_cnt    <= '0;
      pld_cnt    <= '0;
      ks_buf     <= '0;
      idx        <= '0;
      pre_r      <= '0;
      mask_r     <= '0;
      pre_ok     <= 1'b0;
      mask_ok    <= 1'b0;
      tag_r      <= '0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          dir_r      <= dir;
          aad_none_r <= aad_none;
          pld_none_r <= pld_none;
          aad_cnt    <= '0;
          pld_cnt    <= '0;
          idx        <= '0;
          pre_ok     <= 1'b0;
          mask_ok    <= 1'b0;
          state      <= S_CFG;
        end
        S_CFG: state <= !aad_none_r ? S_AAD : (!pld_none_r ? S_KSREQ : S_LEN);
        S_AAD: if (aad_xfer) begin
          aad_cnt <= aad_cnt + CNT_W'(popcount16(aad_in_keep));
          if (aad_in_last) state <= pld_none_r ? S_LEN : S_KSREQ;
        end
        S_KSREQ: state <= S_KSWAIT;
        S_KSWAIT: if (ks_valid) begin
          ks_buf <= ks_data;
          idx    <= '0;
          state  <= S_PLD;
        end
        S_PLD: if (pld_xfer) begin
          pld_cnt <= pld_cnt + CNT_W'(popcount16(in_keep));
          idx     <= idx + 2'd1;
          if (in_last)         state <= S_LEN;
          else if (idx == 2'd3) state <= S_KSREQ;
        end
        S_LEN: if (core_len_ready) state <= S_TAG;
        S_TAG: begin
          if (tag_pre_xor_valid) begin
            pre_r  <= tag_pre_xor;
            pre_ok <= 1'b1;
          end
          if (tagmask_valid) begin
            mask_r  <= tagmask;
            mask_ok <= 1'b1;
          end
          if (pre_have && mask_have) begin
            tag_r <= pre_cur ^ mask_cur;
            state <= S_DONE;
          end
        end
        S_DONE: if (tag_ready) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_chacha_aead_sequencer.sv
// Directed self-checking bench for chacha_aead_sequencer.
module tb_chacha_aead_sequencer;

  logic         clk = 1'b0;
  logic         rst, start, dir, aad_none, pld_none;
  logic         aad_in_valid, aad_in_ready, aad_in_last;
  logic [127:0] aad_in_data;
  logic [15:0]  aad_in_keep;
  logic         in_valid, in_ready, in_last;
  logic [127:0] in_data;
  logic [15:0]  in_keep;
  logic         out_valid, out_ready, out_last;
  logic [127:0] out_data;
  logic [15:0]  out_keep;
  logic         cfg_we, ks_req;
  logic         ks_valid = 1'b0;
  logic [511:0] ks_data = '0;
  logic         core_aad_valid, core_aad_ready;
  logic [127:0] core_aad_data;
  logic [15:0]  core_aad_keep;
  logic         core_pld_valid, core_pld_ready;
  logic [127:0] core_pld_data;
  logic [15:0]  core_pld_keep;
  logic         core_len_valid, core_len_ready;
  logic [127:0] core_len_block;
  logic [127:0] tag_pre_xor, tagmask, tag;
  logic         tag_pre_xor_valid, tagmask_valid, tag_valid, tag_ready, busy;

  int n_cmp = 0;
  int n_bad = 0;
  int cfg_cnt = 0;
  int ksreq_cnt = 0;
  int ks_served = 0;
  int cyc = 0;
  logic [127:0] out_q[$];
  logic [127:0] core_q[$];
  logic [16:0]  meta_q[$];
  logic [15:0]  or_pat = 16'b1011_0110_1101_0011;
  logic [15:0]  cp_pat = 16'b0110_1101_1011_1001;

  localparam logic [127:0] PRE  = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
  localparam logic [127:0] MASK = 128'hFFFF_0000_FFFF_0000_0F0F_0F0F_F0F0_F0F0;
  localparam logic [127:0] TAGX = 128'hFEDC_4567_7654_CDEF_F1D3_B597_86A4_C2E0;

  chacha_aead_sequencer #(.CNT_W(36)) dut (
    .clk(clk), .rst(rst), .start(start), .dir(dir), .aad_none(aad_none), .pld_none(pld_none),
    .aad_in_valid(aad_in_valid), .aad_in_ready(aad_in_ready), .aad_in_data(aad_in_data),
    .aad_in_keep(aad_in_keep), .aad_in_last(aad_in_last),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_keep(in_keep), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_keep(out_keep), .out_last(out_last),
    .cfg_we(cfg_we), .ks_req(ks_req), .ks_valid(ks_valid), .ks_data(ks_data),
    .core_aad_valid(core_aad_valid), .core_aad_data(core_aad_data), .core_aad_keep(core_aad_keep),
    .core_aad_ready(core_aad_ready),
    .core_pld_valid(core_pld_valid), .core_pld_data(core_pld_data), .core_pld_keep(core_pld_keep),
    .core_pld_ready(core_pld_ready),
    .core_len_valid(core_len_valid), .core_len_block(core_len_block), .core_len_ready(core_len_ready),
    .tag_pre_xor(tag_pre_xor), .tagmask(tagmask), .tag_pre_xor_valid(tag_pre_xor_valid),
    .tagmask_valid(tagmask_valid), .tag(tag), .tag_valid(tag_valid), .tag_ready(tag_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Keystream block n: four distinct 128-bit slices.
  function automatic logic [511:0] ks_block(input int n);
    logic [511:0] b;
    for (int s = 0; s < 4; s++)
      b[128*s +: 128] = {4{32'h1357_9BDF + 32'(n*64 + s*7)}} ^
                        {32'hFFFF_0000, 32'h00FF_00FF, 32'h0F0F_0F0F, 32'h3333_3333};
    return b;
  endfunction

  function automatic logic [127:0] pld_word(input logic [127:0] seed, input int i);
    return seed ^ {4{32'(i) * 32'h0101_0101}};
  endfunction

  function automatic logic [127:0] kmask(input logic [15:0] k);
    logic [127:0] m;
    for (int b = 0; b < 16; b++) m[8*b +: 8] = {8{k[b]}};
    return m;
  endfunction

  task automatic check(input string tagn, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tagn, got, exp);
    end
  endtask

  // Keystream responder: answers each ks_req one cycle later with the next block.
  always begin
    @(negedge clk);
    if (ks_req) begin
      @(posedge clk); #1;
      ks_valid = 1'b1;
      ks_data  = ks_block(ks_served);
      ks_served <= ks_served + 1;
      @(posedge clk); #1;
      ks_valid = 1'b0;
    end
  end

  // Output monitor: counts strobes and records every accepted beat.
  always @(negedge clk) begin
    if (cfg_we) cfg_cnt <= cfg_cnt + 1;
    if (ks_req) ksreq_cnt <= ksreq_cnt + 1;
    if (out_valid && out_ready) begin
      out_q.push_back(out_data);
      meta_q.push_back({out_last, out_keep});
    end
    if (core_pld_valid && core_pld_ready) core_q.push_back(core_pld_data);
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic start_op(input logic d, input logic an, input logic pn);
    start = 1'b1; dir = d; aad_none = an; pld_none = pn;
    tick();
    start = 1'b0;
    #1 check("cfg_we_in_cfg", 128'(cfg_we), 128'd1);
  endtask

  task automatic send_aad(input logic [127:0] d, input logic [15:0] k);
    tick();
    aad_in_valid = 1'b1; aad_in_data = d; aad_in_keep = k; aad_in_last = 1'b1;
    core_aad_ready = 1'b1;
    #1;
    check("aad_pass_data", core_aad_data, d);
    check("aad_pass_flags", {core_aad_valid, aad_in_ready, core_aad_keep}, {1'b1, 1'b1, k});
    tick();
    aad_in_valid = 1'b0; aad_in_last = 1'b0;
  endtask

  task automatic send_pld(input int n, input logic [15:0] lk, input bit mark_last,
                          input bit bp, input logic [127:0] seed);
    for (int i = 0; i < n; i++) begin
      int guard;
      guard = 0;
      in_valid = 1'b1;
      in_data  = pld_word(seed, i);
      in_keep  = (i == n - 1) ? lk : 16'hFFFF;
      in_last  = mark_last && (i == n - 1);
      forever begin
        if (bp) begin
          out_ready = or_pat[cyc % 16]; core_pld_ready = cp_pat[cyc % 16]; cyc++;
        end else begin
          out_ready = 1'b1; core_pld_ready = 1'b1;
        end
        @(negedge clk);
        if (in_ready) break;
        @(posedge clk); #1;
        guard++;
        if (guard > 200) begin
          check("pld_timeout", 128'(guard), 128'd0);
          break;
        end
      end
      tick();
    end
    in_valid = 1'b0; in_last = 1'b0;
    out_ready = 1'b1; core_pld_ready = 1'b1;
  endtask

  task automatic check_pld(input int o_base, input int c_base, input int n, input logic [15:0] lk,
                           input logic d, input logic [127:0] seed, input int ks_base);
    check("pld_out_count", 128'(out_q.size() - o_base), 128'(n));
    check("pld_core_count", 128'(core_q.size() - c_base), 128'(n));
    if (out_q.size() - o_base != n || core_q.size() - c_base != n) return;
    for (int i = 0; i < n; i++) begin
      logic [511:0] blk;
      logic [127:0] w, x;
      logic [15:0]  k;
      blk = ks_block(ks_base + i / 4);
      w   = pld_word(seed, i);
      k   = (i == n - 1) ? lk : 16'hFFFF;
      x   = (w ^ blk[128*(i % 4) +: 128]) & kmask(k);
      check("pld_out_data", out_q[o_base + i], x);
      check("pld_core_data", core_q[c_base + i], d ? w : x);
    end
    check("pld_last_meta", 128'(meta_q[o_base + n - 1]), 128'({1'b1, lk}));
  endtask

  task automatic do_len(input logic [127:0] exp);
    int guard;
    guard = 0;
    core_len_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (core_len_valid) break;
      guard++;
      if (guard > 100) begin
        check("len_timeout", 128'(guard), 128'd0);
        break;
      end
    end
    check("len_block", core_len_block, exp);
    tick();
    check("len_valid_hold", 128'(core_len_valid), 128'd1);
    core_len_ready = 1'b1;
    tick();
    core_len_ready = 1'b0;
  endtask

  task automatic do_tag(input int gap, input int hold);
    int guard;
    tag_pre_xor = PRE; tagmask = MASK;
    if (gap == 0) begin
      tag_pre_xor_valid = 1'b1; tagmask_valid = 1'b1;
      tick();
      tag_pre_xor_valid = 1'b0; tagmask_valid = 1'b0;
    end else begin
      tagmask_valid = 1'b1;
      tick();
      tagmask_valid = 1'b0;
      tag_pre_xor = 128'hDEAD_BEEF;
      repeat (gap - 1) tick();
      tag_pre_xor = PRE; tag_pre_xor_valid = 1'b1;
      tick();
      tag_pre_xor_valid = 1'b0;
    end
    guard = 0;
    forever begin
      @(negedge clk);
      if (tag_valid) break;
      guard++;
      if (guard > 50) begin
        check("tag_timeout", 128'(guard), 128'd0);
        break;
      end
    end
    check("tag_value", tag, TAGX);
    for (int h = 0; h < hold; h++) begin
      tick();
      check("tag_valid_hold", {tag_valid, tag}, {1'b1, TAGX});
    end
    tag_ready = 1'b1;
    tick();
    tag_ready = 1'b0;
    check("tag_release", {busy, tag_valid}, 128'd0);
  endtask

  initial begin
    int o_b, c_b, k_b, cf_b, kr_b;
    rst = 1'b1; start = 0; dir = 0; aad_none = 0; pld_none = 0;
    aad_in_valid = 0; aad_in_data = '0; aad_in_keep = '0; aad_in_last = 0;
    in_valid = 0; in_data = '0; in_keep = '0; in_last = 0;
    out_ready = 1; core_aad_ready = 0; core_pld_ready = 1; core_len_ready = 0;
    tag_pre_xor = '0; tagmask = '0; tag_pre_xor_valid = 0; tagmask_valid = 0; tag_ready = 0;
    repeat (2) tick();
    rst = 1'b0;
    #1;
    check("reset_busy_flags", {busy, tag_valid, core_len_valid, cfg_we, ks_req}, 128'd0);
    check("reset_tag", tag, 128'd0);

    // 1: encrypt, 12-byte AAD, 5 payload beats (last 8 bytes)
    o_b = out_q.size(); c_b = core_q.size(); k_b = ks_served; cf_b = cfg_cnt; kr_b = ksreq_cnt;
    start_op(1'b0, 1'b0, 1'b0);
    send_aad(128'h1111_2222_3333_4444_5555_6666_7777_8888, 16'h0FFF);
    send_pld(5, 16'h00FF, 1'b1, 1'b0, 128'hA0A1_A2A3_A4A5_A6A7_A8A9_AAAB_ACAD_AEAF);
    do_len(128'h0000_0000_0000_000C_0000_0000_0000_0048);
    check_pld(o_b, c_b, 5, 16'h00FF, 1'b0, 128'hA0A1_A2A3_A4A5_A6A7_A8A9_AAAB_ACAD_AEAF, k_b);
    check("t1_tail_zero", out_q[o_b + 4] & {64'hFFFF_FFFF_FFFF_FFFF, 64'd0}, 128'd0);
    do_tag(0, 1);
    check("t1_cfg_pulses", 128'(cfg_cnt - cf_b), 128'd1);
    check("t1_ks_pulses", 128'(ksreq_cnt - kr_b), 128'd2);

    // 2: decrypt, no AAD, one all-ones beat
    o_b = out_q.size(); c_b = core_q.size(); k_b = ks_served; kr_b = ksreq_cnt;
    start_op(1'b1, 1'b1, 1'b0);
    send_pld(1, 16'hFFFF, 1'b1, 1'b0, {128{1'b1}});
    do_len(128'h0000_0000_0000_0000_0000_0000_0000_0010);
    check_pld(o_b, c_b, 1, 16'hFFFF, 1'b1, {128{1'b1}}, k_b);
    do_tag(0, 1);
    check("t2_ks_pulses", 128'(ksreq_cnt - kr_b), 128'd1);

    // 3: backpressure on both sinks over 8 beats
    o_b = out_q.size(); c_b = core_q.size(); k_b = ks_served; kr_b = ksreq_cnt;
    start_op(1'b0, 1'b1, 1'b0);
    send_pld(8, 16'hFFFF, 1'b1, 1'b1, 128'h0F1E_2D3C_4B5A_6978_8796_A5B4_C3D2_E1F0);
    do_len(128'h0000_0000_0000_0000_0000_0000_0000_0080);
    check_pld(o_b, c_b, 8, 16'hFFFF, 1'b0, 128'h0F1E_2D3C_4B5A_6978_8796_A5B4_C3D2_E1F0, k_b);
    do_tag(0, 1);
    check("t3_ks_pulses", 128'(ksreq_cnt - kr_b), 128'd2);

    // 4: no AAD, no payload; tag halves 3 cycles apart; tag held 4 cycles
    kr_b = ksreq_cnt;
    start_op(1'b0, 1'b1, 1'b1);
    tick();
    check("t4_cfg_to_len", 128'(core_len_valid), 128'd1);
    do_len(128'd0);
    do_tag(3, 4);
    check("t4_no_ks", 128'(ksreq_cnt - kr_b), 128'd0);

    // 5: reset mid-block in PLD
    start_op(1'b0, 1'b1, 1'b0);
    send_pld(2, 16'hFFFF, 1'b0, 1'b0, 128'h5555_AAAA_5555_AAAA_5555_AAAA_5555_AAAA);
    in_valid = 1'b1; in_data = 128'h1234; in_keep = 16'hFFFF; out_ready = 1; core_pld_ready = 1;
    core_aad_ready = 1; aad_in_valid = 1;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    check("rst_out_data", out_data, 128'd0);
    check("rst_core_pld", core_pld_data, 128'd0);
    check("rst_core_aad", core_aad_data, 128'd0);
    check("rst_len_block", core_len_block, 128'd0);
    check("rst_tag", tag, 128'd0);
    check("rst_flags", {aad_in_ready, in_ready, out_valid, out_last, cfg_we, ks_req, core_aad_valid,
                        core_pld_valid, core_len_valid, tag_valid, busy, out_keep, core_aad_keep,
                        core_pld_keep}, 128'd0);
    in_valid = 1'b0; aad_in_valid = 1'b0; core_aad_ready = 1'b0;

    // 5/6: fresh op after reset; start pulsed while busy is ignored
    o_b = out_q.size(); c_b = core_q.size(); cf_b = cfg_cnt; kr_b = ksreq_cnt;
    start_op(1'b0, 1'b0, 1'b0);
    tick();
    start = 1'b1; dir = 1'b1; aad_none = 1'b1; pld_none = 1'b1;
    tick();
    start = 1'b0;
    k_b = ks_served;
    send_aad(128'hCAFE_F00D_0000_0000_1111_2222_3333_4444, 16'hFFFF);
    send_pld(1, 16'h0001, 1'b1, 1'b0, 128'h0102_0304_0506_0708_090A_0B0C_0D0E_0F10);
    do_len(128'h0000_0000_0000_0010_0000_0000_0000_0001);
    check_pld(o_b, c_b, 1, 16'h0001, 1'b0, 128'h0102_0304_0506_0708_090A_0B0C_0D0E_0F10, k_b);
    do_tag(0, 1);
    check("t6_cfg_once", 128'(cfg_cnt - cf_b), 128'd1);
    check("t6_ks_once", 128'(ksreq_cnt - kr_b), 128'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
